// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: streams a stored register profile into the Altera PLL
// reconfiguration core over Avalon-MM, triggers the reconfiguration, polls
// for completion and waits for the PLL to relock.
//
// Ports:
//   refclk, rst_n        controller clock, asynchronous active-low reset
//   req, req_profile     reconfiguration request and profile (sampled in IDLE)
//   tbl_addr, tbl_q      profile table read port ({profile, index} -> word next cycle)
//   mgmt_*               Avalon-MM master to the reconfig core (zero-latency reads)
//   pll_locked           asynchronous PLL lock indication
//   busy, done, error    status: sequence active, completion pulse, sticky timeout
//   cur_profile          last successfully loaded profile
//
// Optional feature macro: PLL_LOCK_RETRY_EN (one retry from START after the
// first timeout, separated by a 16-cycle quiet gap).
module pll_reconfig_seq #(
    parameter int unsigned NUM_PROFILES = 2,
    parameter int unsigned ENTRIES      = 8,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned PSEL_W       = $clog2(NUM_PROFILES)
) (
    input  logic                              refclk,
    input  logic                              rst_n,
    input  logic                              req,
    input  logic [PSEL_W-1:0]                 req_profile,
    output logic [PSEL_W+$clog2(ENTRIES)-1:0] tbl_addr,
    input  logic [39:0]                       tbl_q,
    output logic [5:0]                        mgmt_address,
    output logic [31:0]                       mgmt_writedata,
    output logic                              mgmt_write,
    output logic                              mgmt_read,
    input  logic [31:0]                       mgmt_readdata,
    input  logic                              mgmt_waitrequest,
    input  logic                              pll_locked,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [PSEL_W-1:0]                 cur_profile
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TA_W  = PSEL_W + IDX_W;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned LCK_W = 2;
`ifdef PLL_LOCK_RETRY_EN
    localparam int unsigned GAP_W = 4;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_MODE, S_FETCH, S_WRITE, S_START, S_POLL, S_LOCKWAIT, S_DONE, S_ERR
`ifdef PLL_LOCK_RETRY_EN
        , S_RETRY
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [5:0]        r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic              r_write, w_write_nxt;
    logic              r_read, w_read_nxt;
    logic [TA_W-1:0]   r_tbl_addr, w_tbl_addr_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt, w_idx_inc;
    logic              r_last, w_last_nxt;
    logic [PSEL_W-1:0] r_prof, w_prof_nxt;
    logic [PSEL_W-1:0] r_cur, w_cur_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_error, w_error_nxt;
    logic [TMO_W-1:0]  r_tmo, w_tmo_nxt;
    logic [LCK_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
    logic              r_lock_meta, r_lock_sync;
`ifdef PLL_LOCK_RETRY_EN
    logic [GAP_W-1:0]  r_gap, w_gap_nxt;
    logic              r_retried, w_retried_nxt;
`endif
    logic              w_xfer, w_tmo_hit, w_last_entry, w_timeout;
    logic              w_unused_bits;

    assign w_xfer        = (r_write | r_read) & ~mgmt_waitrequest;
    assign w_tmo_hit     = (r_tmo == TMO_W'(LOCK_TIMEOUT - 1));
    assign w_idx_inc     = r_idx + IDX_W'(1);
    assign w_last_entry  = r_last | (r_idx == IDX_W'(ENTRIES - 1));
    assign w_unused_bits = ^{mgmt_readdata[31:1], tbl_q[38]};

    // State and registered outputs
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_read      <= 1'b0;
            r_tbl_addr  <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_prof      <= '0;
            r_cur       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_tmo       <= '0;
            r_lock_cnt  <= '0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
`ifdef PLL_LOCK_RETRY_EN
            r_gap       <= '0;
            r_retried   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_write     <= w_write_nxt;
            r_read      <= w_read_nxt;
            r_tbl_addr  <= w_tbl_addr_nxt;
            r_idx       <= w_idx_nxt;
            r_last      <= w_last_nxt;
            r_prof      <= w_prof_nxt;
            r_cur       <= w_cur_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_tmo       <= w_tmo_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
`ifdef PLL_LOCK_RETRY_EN
            r_gap       <= w_gap_nxt;
            r_retried   <= w_retried_nxt;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_write_nxt    = r_write;
        w_read_nxt     = r_read;
        w_tbl_addr_nxt = r_tbl_addr;
        w_idx_nxt      = r_idx;
        w_last_nxt     = r_last;
        w_prof_nxt     = r_prof;
        w_cur_nxt      = r_cur;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_tmo_nxt      = r_tmo;
        w_lock_cnt_nxt = r_lock_cnt;
        w_timeout      = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
        w_gap_nxt      = r_gap;
        w_retried_nxt  = r_retried;
`endif
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_prof_nxt    = req_profile;
                    w_error_nxt   = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_write_nxt   = 1'b1;
                    w_addr_nxt    = 6'd0;
                    w_wdata_nxt   = 32'd1;
`ifdef PLL_LOCK_RETRY_EN
                    w_retried_nxt = 1'b0;
`endif
                    w_state_nxt   = S_MODE;
                end
            end
            S_MODE: begin
                if (w_xfer) begin
                    w_write_nxt    = 1'b0;
                    w_idx_nxt      = '0;
                    w_tbl_addr_nxt = {r_prof, IDX_W'(0)};
                    w_state_nxt    = S_FETCH;
                end
            end
            // Table RAM latency: tbl_q is valid during the first WRITE cycle
            S_FETCH: w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (!r_write) begin
                    w_addr_nxt  = tbl_q[37:32];
                    w_wdata_nxt = tbl_q[31:0];
                    w_last_nxt  = tbl_q[39];
                    w_write_nxt = 1'b1;
                end else if (w_xfer) begin
                    if (w_last_entry) begin
                        w_addr_nxt  = 6'd2;
                        w_wdata_nxt = 32'd0;
                        w_tmo_nxt   = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_write_nxt    = 1'b0;
                        w_idx_nxt      = w_idx_inc;
                        w_tbl_addr_nxt = {r_prof, w_idx_inc};
                        w_state_nxt    = S_FETCH;
                    end
                end
            end
            S_START: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end else if (w_xfer) begin
                    w_write_nxt = 1'b0;
                    w_read_nxt  = 1'b1;
                    w_addr_nxt  = 6'd1;
                    w_state_nxt = S_POLL;
                end
            end
            // Strobe stays high while not done: each completed read is one poll
            S_POLL: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end else if (w_xfer && mgmt_readdata[0]) begin
                    w_read_nxt     = 1'b0;
                    w_lock_cnt_nxt = '0;
                    w_state_nxt    = S_LOCKWAIT;
                end
            end
            S_LOCKWAIT: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (w_tmo_hit) begin
                    w_timeout = 1'b1;
                end else if (!r_lock_sync) begin
                    w_lock_cnt_nxt = '0;
                end else if (r_lock_cnt == LCK_W'(3)) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_cur_nxt   = r_prof;
                    w_state_nxt = S_DONE;
                end else begin
                    w_lock_cnt_nxt = r_lock_cnt + LCK_W'(1);
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            S_ERR:  w_state_nxt = S_IDLE;
`ifdef PLL_LOCK_RETRY_EN
            S_RETRY: begin
                w_gap_nxt = r_gap + GAP_W'(1);
                if (r_gap == GAP_W'(15)) begin
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = 6'd2;
                    w_wdata_nxt = 32'd0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        // Timeout abandons any pending transfer
        if (w_timeout) begin
            w_write_nxt = 1'b0;
            w_read_nxt  = 1'b0;
`ifdef PLL_LOCK_RETRY_EN
            if (!r_retried) begin
                w_retried_nxt = 1'b1;
                w_gap_nxt     = '0;
                w_state_nxt   = S_RETRY;
            end else begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_ERR;
            end
`else
            w_error_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_ERR;
`endif
        end
    end

    assign tbl_addr       = r_tbl_addr;
    assign mgmt_address   = r_addr;
    assign mgmt_writedata = r_wdata;
    assign mgmt_write     = r_write;
    assign mgmt_read      = r_read;
    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign cur_profile    = r_cur;

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
Sequences run-time reprogramming of the system PLL through the Altera PLL reconfiguration core's Avalon-MM management port.
- On request, streams one of NUM_PROFILES stored register sets (M/N/C counters, bandwidth, charge pump) into the reconfig core, then triggers it, polls completion and waits for PLL lock.
- Used to switch video/CPU clock sets (e.g. NTSC/PAL timing). Runs on the 50 MHz reference clock domain.

Parameters:
NUM_PROFILES, 2, number of stored configurations (power of 2, >=2)
ENTRIES, 8, max table entries per profile (power of 2)
LOCK_TIMEOUT, 65535, refclk cycles allowed for status-done plus lock (16-bit counter)
PSEL_W, 1, clog2(NUM_PROFILES)

Ports:
refclk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
req  in  1  reconfiguration request, sampled only in IDLE
req_profile  in  PSEL_W  profile to load, captured with req
tbl_addr  out  PSEL_W+clog2(ENTRIES)  table address {profile, index}
tbl_q  in  40  table word, valid 1 cycle after tbl_addr: [39]=last, [37:32]=reg addr, [31:0]=data
mgmt_address  out  6  reconfig register address
mgmt_writedata  out  32  reconfig write data
mgmt_write  out  1  write strobe
mgmt_read  out  1  read strobe
mgmt_readdata  in  32  read data
mgmt_waitrequest  in  1  slave stall
pll_locked  in  1  PLL locked (asynchronous, 2-flop synchronised internally)
busy  out  1  sequence in progress
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky timeout flag, cleared on next accepted req
cur_profile  out  PSEL_W  last successfully loaded profile

Behaviour:
- Reset: all outputs 0, FSM in IDLE, cur_profile=0, counters 0. Reset mid-sequence aborts immediately; no pending Avalon strobe survives.
- Avalon rule: address/writedata/write/read held stable while mgmt_waitrequest=1; a transfer completes on the first cycle with strobe=1 and waitrequest=0. Read data is captured that same cycle (zero-latency read). Never write and read together.
- FSM:
  - IDLE: req=1 -> latch req_profile, clear error, busy=1 next cycle -> MODE.
  - MODE: write reg 0 = 32'h1 (polling mode) -> FETCH, index=0.
  - FETCH: drive tbl_addr={profile,index}; wait one cycle -> WRITE.
  - WRITE: write tbl_q[37:32] / tbl_q[31:0]. On completion, if tbl_q[39]=1 or index=ENTRIES-1 -> START, else index+1 -> FETCH. Index never wraps.
  - START: write reg 2 = 0 -> POLL; timeout counter cleared.
  - POLL: read reg 1. bit0=1 -> LOCKWAIT, else re-read the next cycle.
  - LOCKWAIT: synchronised lock=1 for 4 consecutive cycles -> DONE.
  - DONE: done=1 for one cycle, cur_profile=latched profile, busy=0 -> IDLE.
  - ERR: error=1, busy=0, cur_profile unchanged -> IDLE.
- Timeout: a single counter runs from START through POLL and LOCKWAIT, reset on entering START. Reaching LOCK_TIMEOUT -> ERR (or retry, see Optional Feature). A lock drop in LOCKWAIT restarts the 4-cycle count without resetting the timeout.
- req while busy is ignored (not queued). A request for the profile already loaded still runs the full sequence.
- Latency with no wait states: 2 + 3·n + 1 + polls + 4 + 1 cycles from req to done, where n = number of table entries used.

Optional Feature:
PLL_LOCK_RETRY_EN
- Defined: the first timeout in a sequence does not go to ERR. It returns to START after a 16-cycle idle gap (no strobes) and reloads the timeout. A second timeout -> ERR. done still pulses once.
- Undefined: the first timeout -> ERR directly; no retry logic present.

Test Plan:
- Profile 1, 3 entries (last flag on entry 2), no waitrequest, status bit0=1 on first poll, lock held high -> exactly 5 writes in order: reg0=1, three table writes, reg2; done pulses at cycle 2+9+1+1+4+1 after req; cur_profile=1.
- Same sequence with waitrequest=1 for 3 cycles on every transfer -> identical write order and data; strobes and address stable through each stall; no duplicate writes.
- Profile with no last flag -> exactly ENTRIES=8 table writes, then reg2; index does not wrap.
- Status bit0=1 but pll_locked held 0, LOCK_TIMEOUT=100 -> error=1 at cycle 100 after START, done never pulses, cur_profile unchanged. With PLL_LOCK_RETRY_EN: second reg2 write follows the 16-cycle gap; error only after the second timeout.
- req pulse while busy with req_profile=0 -> ignored, cur_profile ends at the originally requested value; a subsequent req after done -> accepted, error cleared.
- rst_n asserted during a stalled write -> all outputs 0 within 0 cycles (async); after release, FSM in IDLE, no strobe until the next req.
